// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared constants and types for the RedMulE streamer/TCDM path
package redmule_pkg;

    localparam int unsigned NumStreamSources = 6;
    localparam int unsigned DATA_W           = 544;

    // Stream sources occupy ids 0..NumStreamSources-1, the Z sink takes the last id
    localparam int unsigned NumArbReq  = NumStreamSources + 1;
    localparam int unsigned ZsinkReqId = NumStreamSources;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// rtl/redmule_arb_id_fifo.sv - in-order FIFO of granted requester ids awaiting responses
module redmule_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdW   = 3,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [IdW-1:0]  push_id_i,
    input  logic            pop_i,
    output logic [IdW-1:0]  head_id_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Depth-1:0][IdW-1:0] mem_q, mem_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // The owner never pushes when full nor pops when empty
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_id_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CntW'(Depth));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/redmule_stream_arbiter.sv
// rtl/redmule_stream_arbiter.sv - round-robin/priority arbiter sharing one TCDM port among streamers
module redmule_stream_arbiter
    import redmule_pkg::*;
#(
    parameter int unsigned NumReq         = NumArbReq,
    parameter int unsigned DataW          = DATA_W,
    parameter int unsigned AddrW          = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdW           = $clog2(NumReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              prio_en_i,
    input  logic [IdW-1:0]                    prio_id_i,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq-1:0][AddrW-1:0]      add_i,
    input  logic [NumReq-1:0]                 wen_i,
    input  logic [NumReq-1:0][DataW/8-1:0]    be_i,
    input  logic [NumReq-1:0][DataW-1:0]      data_i,
    output logic [NumReq-1:0]                 gnt_o,
    output logic [NumReq-1:0]                 r_valid_o,
    output logic [DataW-1:0]                  r_data_o,
    output logic                              tcdm_req_o,
    output logic [AddrW-1:0]                  tcdm_add_o,
    output logic                              tcdm_wen_o,
    output logic [DataW/8-1:0]                tcdm_be_o,
    output logic [DataW-1:0]                  tcdm_data_o,
    input  logic                              tcdm_gnt_i,
    input  logic                              tcdm_r_valid_i,
    input  logic [DataW-1:0]                  tcdm_r_data_i,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int unsigned SumW = IdW + 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] lock_id_q, lock_id_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;

    logic [SumW-1:0] scan;
    logic [IdW-1:0]  rr_win, arb_win, sel, head_id;
    logic            rr_found, prio_hit, sel_req, grant, withdraw, orphan, pop;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    // First requester at or after rr_ptr, wrapping modulo NumReq
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        scan     = '0;
        for (int i = 0; i < NumReq; i++) begin
            scan = SumW'(rr_ptr_q) + SumW'(i);
            if (scan >= SumW'(NumReq)) begin
                scan = scan - SumW'(NumReq);
            end
            if (!rr_found && req_i[scan[IdW-1:0]]) begin
                rr_win   = scan[IdW-1:0];
                rr_found = 1'b1;
            end
        end
    end

    assign prio_hit = prio_en_i && ({1'b0, prio_id_i} < SumW'(NumReq)) && req_i[prio_id_i];
    assign arb_win  = prio_hit ? prio_id_i : rr_win;

    assign sel        = (state_q == ARB_LOCKED) ? lock_id_q : arb_win;
    assign sel_req    = (state_q == ARB_LOCKED) ? req_i[lock_id_q] : (|req_i);
    assign withdraw   = (state_q == ARB_LOCKED) && !req_i[lock_id_q];
    assign tcdm_req_o = sel_req && !fifo_full;
    assign grant      = tcdm_req_o && tcdm_gnt_i && !clear_i;
    assign pop        = tcdm_r_valid_i && !fifo_empty;
    assign orphan     = tcdm_r_valid_i && fifo_empty;

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q | orphan | withdraw;
        if (grant) begin
            rr_ptr_d = (sel == IdW'(NumReq - 1)) ? '0 : sel + 1'b1;
        end
        case (state_q)
            ARB_IDLE: begin
                if (tcdm_req_o && !tcdm_gnt_i) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = arb_win;
                end
            end
            ARB_LOCKED: begin
                if (withdraw || grant) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // A flush that discards in-flight ids is itself reported as an error
        if (clear_i) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = '0;
            err_d    = !fifo_empty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    redmule_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .IdW   (IdW)
    ) i_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .push_i    (grant),
        .push_id_i (sel),
        .pop_i     (pop),
        .head_id_o (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign tcdm_add_o  = add_i[sel];
    assign tcdm_wen_o  = wen_i[sel];
    assign tcdm_be_o   = be_i[sel];
    assign tcdm_data_o = data_i[sel];

    assign gnt_o     = grant ? (NumReq'(1) << sel) : '0;
    assign r_valid_o = pop ? (NumReq'(1) << head_id) : '0;
    assign r_data_o  = tcdm_r_data_i;
    assign busy_o    = (fifo_count != '0);
    assign err_o     = err_q;

endmodule

// File: tb/tb_redmule_stream_arbiter.sv
// tb/tb_redmule_stream_arbiter.sv - self-checking bench for redmule_stream_arbiter
module tb_redmule_stream_arbiter;
    import redmule_pkg::*;

    localparam int N  = 7;
    localparam int DW = 544;
    localparam int AW = 32;
    localparam int MO = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clear, prio_en, gnt, rvalid;
    logic [2:0]             prio_id;
    logic [N-1:0]           req;
    logic [N-1:0][AW-1:0]   add;
    logic [N-1:0]           wen;
    logic [N-1:0][DW/8-1:0] be;
    logic [N-1:0][DW-1:0]   wdata;
    logic [N-1:0]           gnt_o, r_valid_o;
    logic [DW-1:0]          r_data_o, tcdm_data_o, tcdm_r_data;
    logic                   tcdm_req_o, tcdm_wen_o, busy_o, err_o;
    logic [AW-1:0]          tcdm_add_o;
    logic [DW/8-1:0]        tcdm_be_o;

    always #5 clk = ~clk;

    redmule_stream_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .prio_en_i      (prio_en),
        .prio_id_i      (prio_id),
        .req_i          (req),
        .add_i          (add),
        .wen_i          (wen),
        .be_i           (be),
        .data_i         (wdata),
        .gnt_o          (gnt_o),
        .r_valid_o      (r_valid_o),
        .r_data_o       (r_data_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_data_o    (tcdm_data_o),
        .tcdm_gnt_i     (gnt),
        .tcdm_r_valid_i (rvalid),
        .tcdm_r_data_i  (tcdm_r_data),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       clr;
        logic       pe;
        logic [2:0] pid;
        logic [6:0] rq;
        logic       g;
        logic       rv;
        logic [6:0] e_gnt;
        logic [6:0] e_rvo;
        logic       e_treq;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic pe, input logic [2:0] pid,
                                input logic [6:0] rq, input logic g, input logic rv,
                                input logic [6:0] eg, input logic [6:0] er,
                                input logic et, input logic eb, input logic ee);
        vec_t v;
        v = {c, pe, pid, rq, g, rv, eg, er, et, eb, ee};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic c, input logic pe, input logic [2:0] pid,
                       input logic [6:0] rq, input logic g, input logic rv);
        clear   = c;
        prio_en = pe;
        prio_id = pid;
        req     = rq;
        gnt     = g;
        rvalid  = rv;
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    function automatic int pick(input logic [6:0] r, input logic pe, input int pid, input int rr);
        if (pe && r[pid]) return pid;
        for (int k = 0; k < N; k++) begin
            if (r[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    int          rr_m, lock_m, sel_m;
    int          q_m[$];
    logic        err_m, treq_m, grant_m, new_err;
    logic [6:0]  rq_r;
    logic [63:0] rd;

    initial begin
        rst_n = 1'b0;
        tcdm_r_data = '0;
        for (int k = 0; k < N; k++) begin
            add[k]   = addr_of(k);
            wdata[k] = {17{32'hC0DE_0000 + 32'(k)}};
            be[k]    = '1;
        end
        wen = 7'h55;
        cyc(0, 0, 0, 7'h00, 0, 0);
        repeat (3) tick();
        chk("reset_gnt", 64'(gnt_o), 0);
        chk("reset_rvalid", 64'(r_valid_o), 0);
        chk("reset_treq", 64'(tcdm_req_o), 0);
        chk("reset_busy", 64'(busy_o), 0);
        chk("reset_err", 64'(err_o), 0);
        rst_n = 1'b1;

        // Rotation, priority, full-FIFO backpressure, orphan and clear
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h01, 7'h00, 1, 0, 0));
        for (int k = 1; k < N; k++) begin
            tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 1, 7'(1 << k), 7'(1 << (k - 1)), 1, 1, 0));
        end
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 1, 7'h01, 7'h40, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h01, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6, 7'h41, 1, 0, 7'h40, 7'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 6, 7'h01, 1, 1, 7'h01, 7'h40, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6, 7'h00, 0, 1, 7'h00, 7'h01, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h02, 7'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h04, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h08, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h10, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 1, 7'h00, 7'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h20, 7'h00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h04, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h08, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h20, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 1, 7'h00, 7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h7F, 1, 0, 7'h01, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 7'h00, 0, 0, 7'h00, 7'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].clr, tbl[i].pe, tbl[i].pid, tbl[i].rq, tbl[i].g, tbl[i].rv);
            chk($sformatf("tbl%0d_gnt", i), 64'(gnt_o), 64'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_rvalid", i), 64'(r_valid_o), 64'(tbl[i].e_rvo));
            chk($sformatf("tbl%0d_treq", i), 64'(tcdm_req_o), 64'(tbl[i].e_treq));
            chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
            tick();
        end

        // Lock on source 2 holds the port while source 6 asserts with priority
        cyc(0, 1, 6, 7'h04, 0, 0);
        chk("lock_treq", 64'(tcdm_req_o), 1);
        chk("lock_add0", 64'(tcdm_add_o), 64'(addr_of(2)));
        tick();
        for (int c = 0; c < 2; c++) begin
            cyc(0, 1, 6, 7'h44, 0, 0);
            chk("lock_add_hold", 64'(tcdm_add_o), 64'(addr_of(2)));
            chk("lock_gnt_none", 64'(gnt_o), 0);
            tick();
        end
        cyc(0, 1, 6, 7'h44, 1, 0);
        chk("lock_gnt", 64'(gnt_o), 64'h04);
        chk("lock_add_final", 64'(tcdm_add_o), 64'(addr_of(2)));
        chk("lock_wdata", 64'(tcdm_data_o[31:0]), 64'h C0DE_0002);
        chk("lock_wen", 64'(tcdm_wen_o), 64'(wen[2]));
        tick();
        cyc(0, 1, 6, 7'h40, 1, 0);
        chk("prio_after_lock", 64'(gnt_o), 64'h40);
        tick();
        cyc(0, 0, 0, 7'h00, 0, 1);
        chk("lock_resp0", 64'(r_valid_o), 64'h04);
        tick();
        cyc(0, 0, 0, 7'h00, 0, 1);
        chk("lock_resp1", 64'(r_valid_o), 64'h40);
        tick();

        // Grants 3,1,5 with response latencies 1,2,2
        cyc(0, 0, 0, 7'h08, 1, 0);
        chk("route_g3", 64'(gnt_o), 64'h08);
        tick();
        tcdm_r_data = {17{32'h1111_0003}};
        cyc(0, 0, 0, 7'h02, 1, 1);
        chk("route_g1", 64'(gnt_o), 64'h02);
        chk("route_rv3", 64'(r_valid_o), 64'h08);
        chk("route_d3", r_data_o[63:0], 64'h1111_0003_1111_0003);
        tick();
        cyc(0, 0, 0, 7'h20, 1, 0);
        chk("route_g5", 64'(gnt_o), 64'h20);
        chk("route_idle", 64'(r_valid_o), 0);
        tick();
        tcdm_r_data = {17{32'h2222_0001}};
        cyc(0, 0, 0, 7'h00, 0, 1);
        chk("route_rv1", 64'(r_valid_o), 64'h02);
        chk("route_d1", r_data_o[63:0], 64'h2222_0001_2222_0001);
        tick();
        tcdm_r_data = {17{32'h3333_0005}};
        cyc(0, 0, 0, 7'h00, 0, 1);
        chk("route_rv5", 64'(r_valid_o), 64'h20);
        chk("route_d5", r_data_o[63:0], 64'h3333_0005_3333_0005);
        tick();

        // Locked source withdraws its request
        cyc(0, 0, 0, 7'h08, 0, 0);
        chk("wd_lock_add", 64'(tcdm_add_o), 64'(addr_of(3)));
        tick();
        cyc(0, 0, 0, 7'h10, 0, 0);
        chk("wd_treq_drop", 64'(tcdm_req_o), 0);
        chk("wd_gnt", 64'(gnt_o), 0);
        tick();
        cyc(0, 0, 0, 7'h10, 0, 0);
        chk("wd_err", 64'(err_o), 1);
        chk("wd_next_treq", 64'(tcdm_req_o), 1);
        chk("wd_next_add", 64'(tcdm_add_o), 64'(addr_of(4)));
        tick();
        cyc(1, 0, 0, 7'h00, 0, 0);
        tick();
        cyc(0, 0, 0, 7'h00, 0, 0);
        chk("wd_err_cleared", 64'(err_o), 0);
        tick();

        // Randomized traffic against a queue-based reference
        rr_m   = 0;
        lock_m = -1;
        err_m  = 1'b0;
        q_m.delete();
        for (int n = 0; n < 2000; n++) begin
            rq_r = 7'($urandom);
            if (lock_m >= 0 && ($urandom % 8) != 0) rq_r[lock_m] = 1'b1;
            rd = {$urandom, $urandom};
            tcdm_r_data = {9{rd}};
            cyc(($urandom % 64) == 0, ($urandom % 3) == 0, 3'($urandom % N), rq_r,
                1'($urandom % 2), (q_m.size() > 0) ? 1'($urandom % 2) : (($urandom % 32) == 0));

            if (lock_m >= 0) begin
                sel_m  = lock_m;
                treq_m = req[lock_m];
            end else begin
                sel_m  = pick(req, prio_en, int'(prio_id), rr_m);
                treq_m = (req != 0);
            end
            treq_m  = treq_m && (q_m.size() < MO);
            grant_m = treq_m && gnt && !clear;

            chk("rnd_treq", 64'(tcdm_req_o), 64'(treq_m));
            chk("rnd_gnt", 64'(gnt_o), grant_m ? 64'(1 << sel_m) : 64'h0);
            chk("rnd_rvalid", 64'(r_valid_o), (rvalid && q_m.size() > 0) ? 64'(1 << q_m[0]) : 64'h0);
            chk("rnd_busy", 64'(busy_o), 64'(q_m.size() > 0));
            chk("rnd_err", 64'(err_o), 64'(err_m));
            if (treq_m) chk("rnd_add", 64'(tcdm_add_o), 64'(addr_of(sel_m)));

            new_err = err_m || (rvalid && q_m.size() == 0) || (lock_m >= 0 && !req[lock_m]);
            if (clear) begin
                err_m  = (q_m.size() > 0);
                q_m.delete();
                rr_m   = 0;
                lock_m = -1;
            end else begin
                err_m = new_err;
                if (rvalid && q_m.size() > 0) void'(q_m.pop_front());
                if (grant_m) begin
                    q_m.push_back(sel_m);
                    rr_m = (sel_m + 1) % N;
                end
                if (lock_m >= 0) begin
                    if (!req[lock_m] || grant_m) lock_m = -1;
                end else if (treq_m && !gnt) begin
                    lock_m = sel_m;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
